abs_value: RTL and testbench
============================

Name: abs_value

Overview:
- Registered two's-complement absolute-value unit used in the CORDIC vectoring datapath.
- Takes a signed WORD_WIDTH operand and returns its unsigned magnitude, one clock later, plus the original sign bit.
- The CORDIC control uses the sign to decide the rotation direction.
- A valid strobe travels alongside the data so the block can sit inside the pipelined iteration chain.

Parameters:
- WORD_WIDTH, 16, bit width of the operand and of the magnitude result (minimum 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies ans on the current clock edge.
- ans  input  WORD_WIDTH  signed two's-complement operand.
- out_valid  output  1  abs_ans and ans_neg are valid this cycle.
- abs_ans  output  WORD_WIDTH  unsigned magnitude of the captured ans.
- ans_neg  output  1  sign bit (MSB) of the captured ans.

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed): out_valid=0, abs_ans=0, ans_neg=0. Outputs hold these values until the first valid capture after rst_n deasserts.
- Arithmetic:
  - If ans[MSB]=0: magnitude = ans unchanged.
  - If ans[MSB]=1: magnitude = (~ans)+1, truncated to WORD_WIDTH bits.
  - Result is interpreted as unsigned.
- Most-negative input (1000…0) gives 1000…0 = 2^(WORD_WIDTH-1). This is the correct unsigned magnitude. No saturation, no overflow flag.
- Zero gives zero with ans_neg=0.
- Latency is exactly 1 cycle, with no backpressure and throughput of one operand per clock.
- On each rising clk edge with in_valid=1: abs_ans <= magnitude, ans_neg <= ans[MSB], out_valid <= 1.
- On each rising clk edge with in_valid=0: out_valid <= 0. abs_ans and ans_neg hold their previous values.
- Back-to-back valid inputs produce back-to-back valid outputs in order.
- If reset asserts mid-stream, the in-flight result is discarded and outputs return to reset values immediately. The first capture after reset release happens on the first clk edge with in_valid=1.
- Combinational path from ans to the register: negate-and-select (mux of ans and its two's complement). The outputs never change except on a clk edge or on reset.
- No X-propagation from ans when in_valid=0: the data registers are not updated.

Test Plan (WORD_WIDTH=16, one valid input per cycle; each result is checked one cycle after its input is applied):
- Reset and positive pass-through:
  - During reset: out_valid=0, abs_ans=0x0000.
  - After release, 0x0F50 -> abs_ans=0x0F50, ans_neg=0.
  - 0x7FFF -> 0x7FFF, ans_neg=0.
  - 0x55A5 -> 0x55A5, ans_neg=0.
- Negative values:
  - 0xFF50 -> 0x00B0, ans_neg=1.
  - 0xFFFF -> 0x0001, ans_neg=1.
  - 0xAAAA -> 0x5556, ans_neg=1.
- Boundaries:
  - 0x8000 -> 0x8000, ans_neg=1.
  - 0x0000 -> 0x0000, ans_neg=0.
- Streaming: drive all eight values above back-to-back with in_valid=1.
  - out_valid stays high for 8 consecutive cycles starting 1 cycle after the first input.
  - Results appear in the same order as the inputs.
- Valid gating:
  - Drive 0xFF50 with in_valid=1, then 0x1234 with in_valid=0.
  - out_valid goes 1 then 0, and abs_ans holds 0x00B0.
- Async reset mid-operation:
  - Assert rst_n=0 between clock edges while out_valid=1.
  - out_valid, abs_ans and ans_neg clear immediately, without waiting for a clock edge.
  - After release, the next valid 0x8000 -> 0x8000, ans_neg=1.

Source files
------------

// File: rtl/abs_value.sv
// Registered two's-complement absolute value with sign output.
// One-cycle latency, valid strobe carried alongside the data.
module abs_value #(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [WORD_WIDTH-1:0] ans,
    output logic                  out_valid,
    output logic [WORD_WIDTH-1:0] abs_ans,
    output logic                  ans_neg
);

    localparam logic [WORD_WIDTH-1:0] ONE = WORD_WIDTH'(1);

    logic                  neg;
    logic [WORD_WIDTH-1:0] negated;
    logic [WORD_WIDTH-1:0] mag;

    // Most-negative input wraps to itself, which is its correct unsigned magnitude.
    always_comb begin
        neg     = ans[WORD_WIDTH-1];
        negated = (~ans) + ONE;
        mag     = neg ? negated : ans;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

    // Data registers only load on a valid operand, so idle inputs never leak through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abs_ans <= '0;
            ans_neg <= 1'b0;
        end else if (in_valid) begin
            abs_ans <= mag;
            ans_neg <= neg;
        end
    end

endmodule

// File: tb/tb_abs_value.sv
// Self-checking bench for abs_value: directed vectors plus a
// randomized run against an integer-arithmetic reference model.
module tb_abs_value;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] ans;
    logic         out_valid;
    logic [W-1:0] abs_ans;
    logic         ans_neg;

    int total;
    int bad;

    abs_value #(.WORD_WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .ans      (ans),
        .out_valid(out_valid),
        .abs_ans  (abs_ans),
        .ans_neg  (ans_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Magnitude via plain signed integer arithmetic.
    function automatic logic [W-1:0] ref_mag(input logic [W-1:0] a);
        int s;
        s = int'($signed(a));
        if (s < 0) s = -s;
        return s[W-1:0];
    endfunction

    function automatic logic ref_neg(input logic [W-1:0] a);
        return int'($signed(a)) < 0;
    endfunction

    task automatic drive(input logic [W-1:0] v, input logic vld);
        @(negedge clk);
        ans      = v;
        in_valid = vld;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        ans      = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || abs_ans !== 16'h0000 || ans_neg !== 1'b0) begin
            bad++;
            $display("FAIL reset: got v=%b abs=%h neg=%b want v=0 abs=0000 neg=0",
                     out_valid, abs_ans, ans_neg);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || abs_ans !== 16'h0000) begin
            bad++;
            $display("FAIL post_release_idle: got v=%b abs=%h want v=0 abs=0000",
                     out_valid, abs_ans);
        end
    endtask

    task automatic test_vectors(input string name, input logic [W-1:0] vals[$],
                                input logic [W-1:0] exp_abs[$], input logic exp_neg[$]);
        foreach (vals[i]) begin
            drive(vals[i], 1'b1);
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1 || abs_ans !== exp_abs[i] || ans_neg !== exp_neg[i]) begin
                bad++;
                $display("FAIL %s[%0d] in=%h: got v=%b abs=%h neg=%b want v=1 abs=%h neg=%b",
                         name, i, vals[i], out_valid, abs_ans, ans_neg, exp_abs[i], exp_neg[i]);
            end
            drive(16'h0000, 1'b0);
        end
    endtask

    task automatic test_positive;
        test_vectors("positive", '{16'h0F50, 16'h7FFF, 16'h55A5},
                     '{16'h0F50, 16'h7FFF, 16'h55A5}, '{1'b0, 1'b0, 1'b0});
    endtask

    task automatic test_negative;
        test_vectors("negative", '{16'hFF50, 16'hFFFF, 16'hAAAA},
                     '{16'h00B0, 16'h0001, 16'h5556}, '{1'b1, 1'b1, 1'b1});
    endtask

    task automatic test_boundary;
        test_vectors("boundary", '{16'h8000, 16'h0000},
                     '{16'h8000, 16'h0000}, '{1'b1, 1'b0});
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] vals[$];
        vals = '{16'h0F50, 16'h7FFF, 16'h55A5, 16'hFF50,
                 16'hFFFF, 16'hAAAA, 16'h8000, 16'h0000};
        @(negedge clk);
        ans      = vals[0];
        in_valid = 1'b1;
        for (int i = 0; i < vals.size(); i++) begin
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1 || abs_ans !== ref_mag(vals[i]) ||
                ans_neg !== ref_neg(vals[i])) begin
                bad++;
                $display("FAIL stream[%0d] in=%h: got v=%b abs=%h neg=%b want v=1 abs=%h neg=%b",
                         i, vals[i], out_valid, abs_ans, ans_neg,
                         ref_mag(vals[i]), ref_neg(vals[i]));
            end
            @(negedge clk);
            if (i + 1 < vals.size()) ans = vals[i+1];
            else in_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stream_end: got v=%b want v=0", out_valid);
        end
    endtask

    task automatic test_valid_gating;
        drive(16'hFF50, 1'b1);
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || abs_ans !== 16'h00B0 || ans_neg !== 1'b1) begin
            bad++;
            $display("FAIL gate_load: got v=%b abs=%h neg=%b want v=1 abs=00b0 neg=1",
                     out_valid, abs_ans, ans_neg);
        end
        drive(16'h1234, 1'b0);
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || abs_ans !== 16'h00B0 || ans_neg !== 1'b1) begin
            bad++;
            $display("FAIL gate_hold: got v=%b abs=%h neg=%b want v=0 abs=00b0 neg=1",
                     out_valid, abs_ans, ans_neg);
        end
    endtask

    task automatic test_async_reset;
        drive(16'hAAAA, 1'b1);
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || abs_ans !== 16'h5556) begin
            bad++;
            $display("FAIL areset_pre: got v=%b abs=%h want v=1 abs=5556",
                     out_valid, abs_ans);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || abs_ans !== 16'h0000 || ans_neg !== 1'b0) begin
            bad++;
            $display("FAIL areset_clear: got v=%b abs=%h neg=%b want v=0 abs=0000 neg=0",
                     out_valid, abs_ans, ans_neg);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        drive(16'h8000, 1'b1);
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || abs_ans !== 16'h8000 || ans_neg !== 1'b1) begin
            bad++;
            $display("FAIL areset_after: got v=%b abs=%h neg=%b want v=1 abs=8000 neg=1",
                     out_valid, abs_ans, ans_neg);
        end
        drive(16'h0000, 1'b0);
    endtask

    task automatic test_random;
        logic [W-1:0] v;
        logic         vld;
        logic [W-1:0] m_abs;
        logic         m_neg;
        logic         m_v;
        m_abs = abs_ans;
        m_neg = ans_neg;
        for (int i = 0; i < 300; i++) begin
            v   = W'($urandom);
            vld = ($urandom_range(0, 3) != 0);
            drive(v, vld);
            m_v = vld;
            if (vld) begin
                m_abs = ref_mag(v);
                m_neg = ref_neg(v);
            end
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== m_v || abs_ans !== m_abs || ans_neg !== m_neg) begin
                bad++;
                $display("FAIL random[%0d] in=%h vld=%b: got v=%b abs=%h neg=%b want v=%b abs=%h neg=%b",
                         i, v, vld, out_valid, abs_ans, ans_neg, m_v, m_abs, m_neg);
            end
        end
        drive(16'h0000, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_positive();
        test_negative();
        test_boundary();
        test_back_to_back();
        test_valid_gating();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
